// File: rtl/regfile_psr.sv
// Register file plus processor status register around the ALU: two combinational
// read ports, one write port, and a per-bit-enabled PSR with branch condition decode.
module regfile_psr #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] ra_a_i,
  input  logic [ADDR_W-1:0] ra_b_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [4:0]        flag_in_i,
  input  logic [4:0]        flag_we_i,
  input  logic              psr_wr_en_i,
  input  logic [4:0]        psr_wr_data_i,
  input  logic [3:0]        cond_i,
  output logic [4:0]        psr_o,
  output logic              carry_out_o,
  output logic              cond_true_o
);

  localparam int unsigned NRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NRegs];
  logic [4:0]        psr_q, psr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_a_o = regs_q[ra_a_i];
    rd_b_o = regs_q[ra_b_i];
    if (BYPASS != 0 && wr_en_i) begin
      if (wr_addr_i == ra_a_i) rd_a_o = wr_data_i;
      if (wr_addr_i == ra_b_i) rd_b_o = wr_data_i;
    end
  end

  // Software load (LPR) overrides ALU flag updates.
  always_comb begin
    psr_d = psr_q;
    if (psr_wr_en_i) begin
      psr_d = psr_wr_data_i;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (flag_we_i[i]) psr_d[i] = flag_in_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) psr_q <= '0;
    else         psr_q <= psr_d;
  end

  logic flag_c, flag_l, flag_f, flag_z, flag_n;
  assign {flag_c, flag_l, flag_f, flag_z, flag_n} = psr_q;

  // Decoded from registered flags only, so same-cycle flag writes are not visible.
  always_comb begin
    cond_true_o = 1'b0;
    unique case (cond_i)
      4'h0: cond_true_o = flag_z;
      4'h1: cond_true_o = !flag_z;
      4'h2: cond_true_o = flag_c;
      4'h3: cond_true_o = !flag_c;
      4'h4: cond_true_o = flag_l;
      4'h5: cond_true_o = !flag_l;
      4'h6: cond_true_o = flag_n;
      4'h7: cond_true_o = !flag_n;
      4'h8: cond_true_o = flag_f;
      4'h9: cond_true_o = !flag_f;
      4'hA: cond_true_o = !flag_l && !flag_z;
      4'hB: cond_true_o = flag_l || flag_z;
      4'hC: cond_true_o = !flag_n && !flag_z;
      4'hD: cond_true_o = flag_n || flag_z;
      4'hE: cond_true_o = 1'b1;
      4'hF: cond_true_o = 1'b0;
      default: cond_true_o = 1'b0;
    endcase
  end

  assign psr_o       = psr_q;
  assign carry_out_o = psr_q[4];

endmodule
